// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the double-dabble add-3 constants.
package bin_to_bcd_seq_pkg;

    // Two-state controller: waiting for a request, or iterating.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // A digit at or above this value would overflow past 9 after the
    // next left shift, so it is corrected first.
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

endpackage : bin_to_bcd_seq_pkg

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Per-digit double-dabble correction: adds 3 to a BCD digit that is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit. Purely combinational.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Conditional add-3; the sum wraps at 4 bits by construction.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESH) begin
            digit_o = digit_i + ADD3_VAL;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// A start accepted in IDLE captures binIn; BIN_W cycles later the result is
// loaded into bcdOut and done pulses for one cycle. bcdOut holds between
// conversions and only changes on the done edge.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int NDIG  = 3
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                start,
    input  logic [BIN_W-1:0]    binIn,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcdOut
);

    localparam int                 CNT_W     = $clog2(BIN_W + 1);
    localparam int                 SCR_W     = 4 * NDIG;
    localparam int                 JOIN_W    = SCR_W + BIN_W;
    localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    // The digit count must be able to represent the largest input value.
    localparam logic [63:0] MAX_IN    = (64'd1 << BIN_W) - 64'd1;
    localparam logic [63:0] DEC_RANGE = 64'd10 ** NDIG;

    if (DEC_RANGE <= MAX_IN) begin : g_ndig_check
        $error("bin_to_bcd_seq: NDIG too small for BIN_W");
    end

    state_e             state_q,   state_d;
    logic [BIN_W-1:0]   shift_q,   shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [SCR_W-1:0]   bcd_q,     bcd_d;

    logic [SCR_W-1:0]   adj_s;
    logic [JOIN_W-1:0]  joined_s;

    // One add-3 corrector per BCD digit of the scratch register.
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // Corrected scratch and shift register moved left as one vector.
    always_comb begin
        joined_s = {adj_s, shift_q} << 1;
    end

    // Next-state logic for the controller and datapath.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = binIn;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                shift_d   = joined_s[BIN_W-1:0];
                scratch_d = joined_s[JOIN_W-1:BIN_W];
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    // This edge completes the final iteration.
                    bcd_d   = joined_s[JOIN_W-1:BIN_W];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign bcdOut = bcd_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=8, NDIG=3).
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [7:0]  binIn;
    logic        busy;
    logic        done;
    logic [11:0] bcdOut;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [10];

    bin_to_bcd_seq #(.BIN_W(8), .NDIG(3)) dut (
        .clk    (clk),
        .rstN   (rstN),
        .start  (start),
        .binIn  (binIn),
        .busy   (busy),
        .done   (done),
        .bcdOut (bcdOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic digits_ok(input logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    // Called at a negedge with the DUT idle. Returns the number of clock
    // edges from capture to done (-1 on timeout), the result, and whether
    // bcdOut stayed constant while busy. Optionally raises start for one
    // edge during the conversion. Leaves time at the negedge of the done cycle.
    task automatic run_conv(input logic [7:0] v, input int inj_cycle, input logic [7:0] inj_v,
                            output int lat, output logic [11:0] res, output logic held);
        logic [11:0] prev;
        prev  = bcdOut;
        held  = 1'b1;
        lat   = -1;
        res   = 12'hxxx;
        start = 1'b1;
        binIn = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        binIn = ~v;
        check("busy_after_capture", {31'd0, busy}, 32'd1);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                res = bcdOut;
                break;
            end
            if (bcdOut !== prev) held = 1'b0;
            start = (n == inj_cycle);
            if (n == inj_cycle) binIn = inj_v;
        end
        start = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [11:0] res;
        logic        held;
        int          ndone;

        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd1,   12'h001};
        vecs[5] = '{8'd10,  12'h010};
        vecs[6] = '{8'd200, 12'h200};
        vecs[7] = '{8'd159, 12'h159};
        vecs[8] = '{8'd9,   12'h009};
        vecs[9] = '{8'd64,  12'h064};

        rstN  = 1'b0;
        start = 1'b0;
        binIn = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_bcdOut", {20'd0, bcdOut}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bin, 0, 8'd0, lat, res, held);
            check("vec_latency", 32'(lat), 32'd8);
            check("vec_bcdOut", {20'd0, res}, {20'd0, vecs[i].exp});
            check("vec_hold_while_busy", {31'd0, held}, 32'd1);
            check("vec_busy_at_done", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("vec_done_one_cycle", {31'd0, done}, 32'd0);
        end

        // Start during busy is ignored.
        run_conv(8'd42, 3, 8'd7, lat, res, held);
        check("ignore_latency", 32'(lat), 32'd8);
        check("ignore_bcdOut", {20'd0, res}, 32'h042);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ignore_no_second_done", 32'(ndone), 32'd0);
        check("ignore_busy_idle", {31'd0, busy}, 32'd0);
        check("ignore_bcdOut_held", {20'd0, bcdOut}, 32'h042);

        // Back-to-back: start raised in the done cycle.
        run_conv(8'd128, 0, 8'd0, lat, res, held);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_bcdOut", {20'd0, res}, 32'h128);
        run_conv(8'd9, 0, 8'd0, lat, res, held);
        check("b2b_second_latency_from_capture", 32'(lat), 32'd8);
        check("b2b_second_bcdOut", {20'd0, res}, 32'h009);
        check("b2b_hold_while_busy", {31'd0, held}, 32'd1);
        @(negedge clk);

        // Reset in the middle of a conversion.
        start = 1'b1;
        binIn = 8'd200;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before_reset", {31'd0, busy}, 32'd1);
        rstN = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcdOut", {20'd0, bcdOut}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        ndone = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        run_conv(8'd77, 0, 8'd0, lat, res, held);
        check("post_reset_latency", 32'(lat), 32'd8);
        check("post_reset_bcdOut", {20'd0, res}, 32'h077);
        @(negedge clk);

        // Exhaustive sweep against the decimal reference.
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), 0, 8'd0, lat, res, held);
            check("sweep_latency", 32'(lat), 32'd8);
            check("sweep_bcdOut", {20'd0, res}, {20'd0, ref_bcd(v)});
            check("sweep_digits_le9", {31'd0, digits_ok(res)}, 32'd1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
